traceback_unit: RTL and testbench
=================================

// Module: traceback_unit
// PURPOSE
//  Parametrised Viterbi survivor-memory + traceback stage. Stores one column of
//  ACS decision bits per trellis step, then, at frame end, walks the survivor
//  path backwards from the selected end state and emits the decoded frame.
//  Sits after the ACS/path-metric unit; output feeds the frame sink.
// PARAMETERS
//  K          3   constraint length; state width SW=K-1, NUM_ST=2**(K-1)
//  FRAME_LEN  8   max decoded bits per frame = survivor columns stored
//  PW         $clog2(FRAME_LEN)  column pointer width (derived, localparam)
// PORTS
//  clk             in   1          clock, rising edge
//  rst             in   1          async reset, active-low
//  i_dec_valid     in   1          decision column valid this cycle
//  i_dec           in   NUM_ST     decision bit per state (bit s -> state s)
//  i_last          in   1          qualifies i_dec_valid: final column of frame
//  i_sel_node      in   SW         best end state, sampled with i_last
//  o_decoder_data  out  FRAME_LEN  decoded frame, bit j = trellis step j
//  o_decoder_done  out  1          1-cycle pulse: o_decoder_data updated
//  o_busy          out  1          high while tracing; columns not accepted
// BEHAVIOUR
//  - Single clock clk; reset rst asynchronous, active-low. Reset: FSM=IDLE,
//    wr_ptr=0, o_decoder_data=0, o_decoder_done=0, o_busy=0; memory not cleared.
//  - FSM IDLE/TRACE/DONE.
//  - IDLE: on i_dec_valid write i_dec to mem[wr_ptr]. If i_last or
//    wr_ptr==FRAME_LEN-1 (forced last): latch cur_st=i_sel_node, rd_ptr=wr_ptr,
//    n_bits=wr_ptr+1, clear shadow data reg, wr_ptr<=0, go TRACE.
//    Else wr_ptr<=wr_ptr+1.
//  - TRACE (o_busy=1), one column per cycle:
//    bit    = cur_st[SW-1] (MSB = newest input bit); shadow[rd_ptr] <= bit
//    d      = mem[rd_ptr][cur_st]
//    cur_st <= {cur_st[SW-2:0], d}   (predecessor; K=2 => cur_st<=d)
//    rd_ptr==0 -> DONE, else rd_ptr<=rd_ptr-1.
//  - DONE: o_decoder_data<=shadow (bits >= n_bits are 0), o_decoder_done=1
//    for exactly this cycle, o_busy=0, -> IDLE. No input column accepted here.
//  - Latency: last column at edge T -> o_decoder_done high in cycle
//    T+n_bits+1; o_busy high cycles T+1..T+n_bits.
//  - i_dec_valid while o_busy or in DONE: column dropped, wr_ptr unchanged.
//  - i_last without i_dec_valid: ignored.
//  - o_decoder_data holds value between done pulses.
//  - rst asserted mid-TRACE: trace aborted, no done pulse, data reg = 0.
//  - Pointer arithmetic unsigned PW bits; no wrap: forced last at FRAME_LEN-1.
// CONFIGURATION
//  TB_ZERO_TERM_EN defined: encoder frames are zero-tail terminated; traceback
//    always starts from state 0, i_sel_node ignored (port kept, unused).
//  Undefined: start state = i_sel_node latched with the last column.
// TESTING
//  1. K=3,FRAME_LEN=8: ideal decisions from encoding 8'hB2, end st 2'b10, 8
//     cols, i_last on col 7 -> o_decoder_data=8'hB2, done 9 cycles after last.
//  2. All-zero msg, all i_dec=0, sel 0 -> data 8'h00, one done pulse, busy 8 cyc.
//  3. Short frame: 5 cols of msg 5'b10011, i_last on col 4 -> data 8'h13,
//     done 6 cycles after last, bits [7:5]=0.
//  4. No i_last for 8 cols (msg 8'h5A) -> forced last, data 8'h5A; valid
//     columns during busy dropped, next frame starts at wr_ptr=0 correctly.
//  5. rst low 3 cycles into TRACE -> no done, data=0, busy=0; next frame
//     8'hC3 decodes correctly.
//  6. TB_ZERO_TERM_EN: zero-terminated msg 8'h2C, i_sel_node=2'b11 -> 8'h2C;
//     without macro same stim with sel 2'b00 -> 8'h2C.

Source files
------------

// File: rtl/traceback_unit.sv
// Viterbi survivor memory + traceback; optional zero-tail start state via TB_ZERO_TERM_EN.
// Latency: last column at edge T -> o_decoder_done in cycle T+n_bits+1 (one column traced per cycle).
// Backpressure: o_busy high while tracing; columns offered while busy or in DONE are dropped.
module traceback_unit #(
  parameter int K         = 3,
  parameter int FRAME_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_dec_valid,
  input  logic [(1<<(K-1))-1:0]   i_dec,
  input  logic                    i_last,
  input  logic [K-2:0]            i_sel_node,
  output logic [FRAME_LEN-1:0]    o_decoder_data,
  output logic                    o_decoder_done,
  output logic                    o_busy
);

  localparam int SW     = K - 1;
  localparam int NUM_ST = 1 << SW;
  localparam int PW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [SW-1:0]         cur_st;
  logic [FRAME_LEN-1:0]  shadow;
  logic [NUM_ST-1:0]     mem [FRAME_LEN];

  logic                  col_wr;
  logic                  col_last;
  logic [SW-1:0]         start_st;
  logic                  dec_bit;
  logic [SW-1:0]         pred_st;
  logic [FRAME_LEN-1:0]  shadow_upd;

`ifdef TB_ZERO_TERM_EN
  // Encoder frames are flushed to state 0, so the end state is known a priori.
  logic unused_sel;
  assign unused_sel = ^i_sel_node;
  assign start_st   = '0;
`else
  assign start_st   = i_sel_node;
`endif

  // Column acceptance and frame-end detection (explicit i_last or memory full).
  always_comb begin
    col_wr   = (state == IDLE) && i_dec_valid;
    col_last = i_last || (wr_ptr == PW'(FRAME_LEN - 1));
  end

  // One traceback step: emit newest input bit, then step to the predecessor state.
  always_comb begin
    dec_bit            = cur_st[SW-1];
    pred_st            = SW'({cur_st, mem[rd_ptr][cur_st]});
    shadow_upd         = shadow;
    shadow_upd[rd_ptr] = dec_bit;
  end

  // Survivor memory is not reset; only columns belonging to the current frame are read.
  always_ff @(posedge clk) begin
    if (col_wr) begin
      mem[wr_ptr] <= i_dec;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt      = state;
    o_busy         = 1'b0;
    o_decoder_done = 1'b0;
    case (state)
      IDLE: begin
        if (col_wr && col_last) begin
          state_nxt = TRACE;
        end
      end
      TRACE: begin
        o_busy = 1'b1;
        if (rd_ptr == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_decoder_done = 1'b1;
        state_nxt      = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: write pointer, traceback pointer/state, shadow and published frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cur_st         <= '0;
      shadow         <= '0;
      o_decoder_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (col_wr) begin
            if (col_last) begin
              cur_st <= start_st;
              rd_ptr <= wr_ptr;
              shadow <= '0;
              wr_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        TRACE: begin
          shadow <= shadow_upd;
          cur_st <= pred_st;
          if (rd_ptr == '0) begin
            // Publish on entry to DONE so data is valid alongside the done pulse.
            o_decoder_data <= shadow_upd;
          end else begin
            rd_ptr <= rd_ptr - PW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Self-checking bench for traceback_unit: directed frames plus random frames vs an encoder-based model.
// Latency: expects done exactly n+1 cycles after the last column, busy for the n cycles before it.
// Backpressure: drives junk columns while busy/done and expects them to be dropped.
module tb_traceback_unit;

  localparam int K  = 3;
  localparam int FL = 8;
  localparam int SW = K - 1;
  localparam int NS = 1 << SW;

`ifdef TB_ZERO_TERM_EN
  localparam bit ZT = 1'b1;
`else
  localparam bit ZT = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          i_dec_valid;
  logic [NS-1:0] i_dec;
  logic          i_last;
  logic [SW-1:0] i_sel_node;
  logic [FL-1:0] o_decoder_data;
  logic          o_decoder_done;
  logic          o_busy;

  int checks = 0;
  int errors = 0;

  logic [NS-1:0] cols [FL];
  logic [FL-1:0] exp_data;
  logic [SW-1:0] end_st;

  traceback_unit #(.K(K), .FRAME_LEN(FL)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_dec_valid    (i_dec_valid),
    .i_dec          (i_dec),
    .i_last         (i_last),
    .i_sel_node     (i_sel_node),
    .o_decoder_data (o_decoder_data),
    .o_decoder_done (o_decoder_done),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Model: run the message through the shift-register encoder state sequence.
  // The survivor decision at state s of step j is the bit that fell out of the
  // register (LSB of the previous state); off-path decisions are arbitrary.
  // An ideal traceback therefore recovers exactly the message bits.
  task automatic build(input logic [FL-1:0] msg_in, input int n, input bit rnd);
    logic [FL-1:0] msg;
    int prev;
    int s;
    msg = msg_in;
    if (ZT) begin
      for (int j = n - SW; j < n; j++) if (j >= 0) msg[j] = 1'b0;
    end
    exp_data = '0;
    prev = 0;
    for (int j = 0; j < n; j++) begin
      exp_data[j] = msg[j];
      s = (int'(msg[j]) << (SW - 1)) | (prev >> 1);
      cols[j] = rnd ? NS'($urandom) : '0;
      cols[j][s] = prev[0];
      prev = s;
    end
    end_st = SW'(prev);
  endtask

  task automatic send_col(input logic [NS-1:0] d, input logic last, input logic [SW-1:0] sel);
    i_dec_valid = 1'b1;
    i_dec       = d;
    i_last      = last;
    i_sel_node  = sel;
    @(posedge clk);
    #1;
    i_dec_valid = 1'b0;
    i_last      = 1'b0;
  endtask

  task automatic run_frame(input logic [FL-1:0] msg, input int n, input bit use_last,
                           input bit junk, input bit rnd, input bit ovr,
                           input logic [SW-1:0] sel_ovr, input string tag);
    logic [SW-1:0] sel;
    build(msg, n, rnd);
    sel = ovr ? sel_ovr : end_st;
    for (int j = 0; j < n; j++) send_col(cols[j], use_last && (j == n - 1), sel);
    for (int c = 1; c <= n + 1; c++) begin
      if (junk) begin
        i_dec_valid = 1'b1;
        i_dec       = NS'($urandom);
        i_last      = 1'($urandom);
      end
      @(negedge clk);
      chk({tag, "_busy"}, 32'(o_busy), 32'(c <= n));
      chk({tag, "_done"}, 32'(o_decoder_done), 32'(c == n + 1));
      if (c == n + 1) chk({tag, "_data"}, 32'(o_decoder_data), 32'(exp_data));
      @(posedge clk);
      #1;
    end
    i_dec_valid = 1'b0;
    i_last      = 1'b0;
    @(negedge clk);
    chk({tag, "_single_pulse"}, 32'(o_decoder_done), 32'd0);
    chk({tag, "_hold"}, 32'(o_decoder_data), 32'(exp_data));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit ul;
    rst         = 1'b0;
    i_dec_valid = 1'b0;
    i_dec       = '0;
    i_last      = 1'b0;
    i_sel_node  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_decoder_done), 32'd0);
    chk("rst_data", 32'(o_decoder_data), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full frame with explicit last.
    run_frame(8'hB2, 8, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "b2");
    // All-zero message with all-zero decisions.
    run_frame(8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, "zero");
    // Short frame: upper bits must read zero.
    run_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "short");

    // Lone i_last without valid must not start a frame.
    i_last = 1'b1;
    @(posedge clk);
    #1;
    i_last = 1'b0;
    @(negedge clk);
    chk("lone_last_busy", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;

    // Forced last at full memory, junk columns offered during busy/done.
    run_frame(8'h5A, 8, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, "forced");
    // Next frame must start from column 0.
    run_frame(8'h96, 6, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "after_forced");

    // Reset during traceback.
    build(8'h77, 8, 1'b1);
    for (int j = 0; j < 8; j++) send_col(cols[j], j == 7, end_st);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("pre_abort_busy", 32'(o_busy), 32'd1);
      if (c < 2) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_busy", 32'(o_busy), 32'd0);
      chk("abort_done", 32'(o_decoder_done), 32'd0);
      chk("abort_data", 32'(o_decoder_data), 32'd0);
    end
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_abort_done", 32'(o_decoder_done), 32'd0);
    @(posedge clk);
    #1;
    run_frame(8'hC3, 8, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "c3");

    // Zero-terminated frame; selected node is ignored when the zero-tail build is used.
    run_frame(8'h2C, 8, 1'b1, 1'b0, 1'b1, 1'b1, ZT ? 2'b11 : 2'b00, "zterm");

    // Random frames of random length.
    for (int r = 0; r < 12; r++) begin
      n  = $urandom_range(1, FL);
      ul = (n < FL) ? 1'b1 : 1'($urandom);
      run_frame(FL'($urandom), n, ul, 1'($urandom), 1'b1, 1'b0, 2'b00, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
